// File: rtl/seq_chunk_packer_pkg.sv
// seq_chunk_packer_pkg: base codes and chunk sizing shared with the PE array controller and PE
`ifndef PE_Array_size
`define PE_Array_size 16
`endif
`define CHUNK_W(n) (2*(n))
package seq_chunk_packer_pkg;
  typedef enum logic [1:0] {BASE_A = 2'b00, BASE_C = 2'b01, BASE_G = 2'b10, BASE_T = 2'b11} base_e;
  localparam int PE_ARRAY_SIZE = `PE_Array_size;
  localparam int BASE_W = 2;
endpackage

// File: rtl/seq_chunk_buf.sv
// seq_chunk_buf: one chunk register with per-lane mask, last flag and full flag
module seq_chunk_buf import seq_chunk_packer_pkg::*; #(
  parameter int PE_NUM = PE_ARRAY_SIZE,
  localparam int LW = $clog2(PE_NUM)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  logic [LW-1:0]            lane_i,
  input  logic [BASE_W-1:0]        base_i,
  input  logic                     last_i,
  input  logic                     ld_i,
  input  logic [BASE_W*PE_NUM-1:0] ld_data_i,
  input  logic [PE_NUM-1:0]        ld_mask_i,
  input  logic                     ld_last_i,
  input  logic                     clr_i,
  output logic [BASE_W*PE_NUM-1:0] data_o,
  output logic [PE_NUM-1:0]        mask_o,
  output logic                     last_o,
  output logic                     full_o
);
  logic [BASE_W*PE_NUM-1:0] data_q;
  logic [PE_NUM-1:0]        mask_q;
  logic                     last_q, full_q;
  // load beats clear so a same-cycle consume and refill keeps the new chunk
  always_ff @(posedge clk) begin
    if (!rst_n || (clr_i && !ld_i)) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
    end else if (ld_i) begin
      data_q <= ld_data_i;
      mask_q <= ld_mask_i;
      last_q <= ld_last_i;
      full_q <= 1'b1;
    end else if (wr_i) begin
      data_q[BASE_W*lane_i +: BASE_W] <= base_i;
      mask_q[lane_i] <= 1'b1;
      last_q <= last_i;
      full_q <= last_i || lane_i == LW'(PE_NUM-1);
    end
  end
  assign data_o = data_q;
  assign mask_o = mask_q;
  assign last_o = last_q;
  assign full_o = full_q;
endmodule

// File: rtl/seq_chunk_packer.sv
// seq_chunk_packer: double-buffered packer of a 2-bit base stream into PE-wide chunks
// SEQ_COUNT_EN adds the saturating seq_len counter port
module seq_chunk_packer import seq_chunk_packer_pkg::*; #(
  parameter int PE_NUM = `PE_Array_size
`ifdef SEQ_COUNT_EN
  , parameter int CNT_W = 16
`endif
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    base_in,
  input  logic                          base_valid,
  input  logic                          base_last,
  output logic                          base_ready,
  input  logic                          request,
  output logic [`CHUNK_W(PE_NUM)-1:0]   chunk_out,
  output logic [PE_NUM-1:0]             chunk_valid,
  output logic                          chunk_last,
  output logic                          chunk_avail
`ifdef SEQ_COUNT_EN
  , output logic [CNT_W-1:0]            seq_len
`endif
);
  localparam int LW = $clog2(PE_NUM);
  logic                         run_q;
  logic [LW-1:0]                fill_cnt_q, fill_cnt_d;
  logic [`CHUNK_W(PE_NUM)-1:0]  fill_data, out_data, chunk_out_q;
  logic [PE_NUM-1:0]            fill_mask, out_mask, chunk_valid_q;
  logic                         fill_last, fill_full, out_last, out_full, chunk_last_q;
  logic                         accept, consume, move;
  assign base_ready = run_q && !fill_full;
  assign accept = base_valid && base_ready;
  assign consume = request && out_full;
  assign move = fill_full && (!out_full || consume);
  seq_chunk_buf #(.PE_NUM(PE_NUM)) u_fill (
    .clk(clk), .rst_n(rst_n),
    .wr_i(accept), .lane_i(fill_cnt_q), .base_i(base_in), .last_i(base_last),
    .ld_i(1'b0), .ld_data_i('0), .ld_mask_i('0), .ld_last_i(1'b0), .clr_i(move),
    .data_o(fill_data), .mask_o(fill_mask), .last_o(fill_last), .full_o(fill_full)
  );
  seq_chunk_buf #(.PE_NUM(PE_NUM)) u_out (
    .clk(clk), .rst_n(rst_n),
    .wr_i(1'b0), .lane_i('0), .base_i(2'b00), .last_i(1'b0),
    .ld_i(move), .ld_data_i(fill_data), .ld_mask_i(fill_mask), .ld_last_i(fill_last),
    .clr_i(consume),
    .data_o(out_data), .mask_o(out_mask), .last_o(out_last), .full_o(out_full)
  );
  always_comb fill_cnt_d = move ? '0 : accept ? fill_cnt_q + LW'(1) : fill_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      fill_cnt_q <= '0;
      chunk_out_q <= '0;
      chunk_valid_q <= '0;
      chunk_last_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      fill_cnt_q <= fill_cnt_d;
      if (request) begin
        chunk_out_q <= out_full ? out_data : '0;
        chunk_valid_q <= out_full ? out_mask : '0;
        chunk_last_q <= out_full && out_last;
      end
    end
  end
  assign chunk_out = chunk_out_q;
  assign chunk_valid = chunk_valid_q;
  assign chunk_last = chunk_last_q;
  assign chunk_avail = out_full;
`ifdef SEQ_COUNT_EN
  logic [CNT_W-1:0] seq_len_q;
  logic             seq_done_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_len_q <= '0;
      seq_done_q <= 1'b0;
    end else if (accept) begin
      seq_len_q <= seq_done_q ? CNT_W'(1) : &seq_len_q ? seq_len_q : seq_len_q + CNT_W'(1);
      seq_done_q <= base_last;
    end
  end
  assign seq_len = seq_len_q;
`endif
endmodule

// File: tb/tb_seq_chunk_packer.sv
// tb_seq_chunk_packer: directed and random stream tests against a queue-based chunk model
module tb_seq_chunk_packer;
  localparam int PE = 4;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      base_in = 2'b00;
  logic            base_valid = 1'b0, base_last = 1'b0, request = 1'b0;
  logic            base_ready, chunk_last, chunk_avail;
  logic [2*PE-1:0] chunk_out;
  logic [PE-1:0]   chunk_valid;
`ifdef SEQ_COUNT_EN
  logic [15:0]     seq_len;
`endif
  int total = 0, bad = 0, delivered = 0;
  logic [1:0]      src_b[$];
  bit              src_l[$];
  int              src_i = 0;
  logic [2*PE-1:0] exp_d[$];
  logic [PE-1:0]   exp_m[$];
  bit              exp_l[$];
  logic [2*PE-1:0] cur_d = '0;
  logic [PE-1:0]   cur_m = '0;
  int              cur_n = 0;

  seq_chunk_packer #(.PE_NUM(PE)) dut (
    .clk(clk), .rst_n(rst_n), .base_in(base_in), .base_valid(base_valid),
    .base_last(base_last), .base_ready(base_ready), .request(request),
    .chunk_out(chunk_out), .chunk_valid(chunk_valid), .chunk_last(chunk_last),
    .chunk_avail(chunk_avail)
`ifdef SEQ_COUNT_EN
    , .seq_len(seq_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic add(input logic [1:0] b, input bit l);
    src_b.push_back(b);
    src_l.push_back(l);
  endtask

  task automatic model_push(input logic [1:0] b, input bit l);
    cur_d[2*cur_n +: 2] = b;
    cur_m[cur_n] = 1'b1;
    cur_n++;
    if (cur_n == PE || l) begin
      exp_d.push_back(cur_d);
      exp_m.push_back(cur_m);
      exp_l.push_back(l);
      cur_d = '0;
      cur_m = '0;
      cur_n = 0;
    end
  endtask

  task automatic step(input bit v, input bit r);
    bit acc, av;
    base_valid = v && src_i < src_b.size();
    base_in = base_valid ? src_b[src_i] : 2'b00;
    base_last = base_valid ? src_l[src_i] : 1'b0;
    request = r;
    acc = base_valid && base_ready;
    av = chunk_avail;
    @(negedge clk);
    base_valid = 1'b0;
    base_last = 1'b0;
    request = 1'b0;
    if (acc) begin
      model_push(src_b[src_i], src_l[src_i]);
      src_i++;
    end
    if (r && av) begin
      chk("chunk_expected", 32'(exp_d.size() > 0), 1);
      if (exp_d.size() > 0) begin
        chk("chunk_out", 32'(chunk_out), 32'(exp_d.pop_front()));
        chk("chunk_valid", 32'(chunk_valid), 32'(exp_m.pop_front()));
        chk("chunk_last", 32'(chunk_last), 32'(exp_l.pop_front()));
        delivered++;
      end
    end else if (r) begin
      chk("bubble_valid", 32'(chunk_valid), 0);
      chk("bubble_last", 32'(chunk_last), 0);
    end
  endtask

  task automatic drain(input int bound);
    for (int k = 0; k < bound && (exp_d.size() > 0 || src_i < src_b.size()); k++)
      step(1'b1, chunk_avail);
    chk("drain_src", src_i, src_b.size());
    chk("drain_exp", exp_d.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(chunk_out), 0);
    chk("rst_valid", 32'(chunk_valid), 0);
    chk("rst_last", 32'(chunk_last), 0);
    chk("rst_avail", 32'(chunk_avail), 0);
    chk("rst_ready", 32'(base_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(base_ready), 1);
    // bubble request with nothing available
    step(1'b0, 1'b1);
    // A,C,G,T with latency check
    add(2'b00, 0); add(2'b01, 0); add(2'b10, 0); add(2'b11, 1);
    repeat (4) step(1'b1, 1'b0);
    chk("avail_lat_n", 32'(chunk_avail), 0);
    step(1'b0, 1'b0);
    chk("avail_lat_n1", 32'(chunk_avail), 1);
    step(1'b0, 1'b1);
    chk("acgt_data", 32'(chunk_out), 32'h0000_00e4);
    chk("acgt_mask", 32'(chunk_valid), 32'h0000_000f);
    chk("acgt_last", 32'(chunk_last), 1);
    chk("acgt_avail_drop", 32'(chunk_avail), 0);
    // six C bases, last on the sixth
    for (int i = 0; i < 6; i++) add(2'b01, i == 5);
    drain(60);
    chk("c6_data", 32'(chunk_out), 32'h0000_0005);
    chk("c6_mask", 32'(chunk_valid), 32'h0000_0003);
    chk("c6_last", 32'(chunk_last), 1);
    // twelve bases with no request: stall after eight
    begin
      int s0;
      s0 = src_i;
      for (int i = 0; i < 12; i++) add(2'(i), i == 11);
      repeat (20) step(1'b1, 1'b0);
      chk("stall_accepted", src_i - s0, 8);
      chk("stall_ready", 32'(base_ready), 0);
      chk("stall_avail", 32'(chunk_avail), 1);
      s0 = delivered;
      step(1'b1, 1'b1);
      chk("ready_returns", 32'(base_ready), 1);
      drain(60);
      chk("stall_chunks", delivered - s0, 3);
    end
    step(1'b0, 1'b1);
`ifdef SEQ_COUNT_EN
    for (int i = 0; i < 5; i++) add(2'b10, i == 4);
    for (int k = 0; k < 30 && src_i < src_b.size(); k++) step(1'b1, 1'b0);
    chk("seq_len_5", 32'(seq_len), 5);
    drain(60);
    chk("seq_len_hold", 32'(seq_len), 5);
    add(2'b11, 1);
    drain(60);
    chk("seq_len_1", 32'(seq_len), 1);
`endif
    // reset mid-fill with out buffer full
    for (int i = 0; i < 6; i++) add(2'b11, 0);
    repeat (8) step(1'b1, 1'b0);
    chk("pre_rst_avail", 32'(chunk_avail), 1);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    chk("mid_rst_out", 32'(chunk_out), 0);
    chk("mid_rst_valid", 32'(chunk_valid), 0);
    chk("mid_rst_avail", 32'(chunk_avail), 0);
    chk("mid_rst_ready", 32'(base_ready), 0);
    src_b.delete(); src_l.delete(); src_i = 0;
    exp_d.delete(); exp_m.delete(); exp_l.delete();
    cur_d = '0; cur_m = '0; cur_n = 0;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    add(2'b00, 0); add(2'b01, 0); add(2'b10, 0); add(2'b11, 1);
    drain(60);
    chk("post_rst_data", 32'(chunk_out), 32'h0000_00e4);
    chk("post_rst_mask", 32'(chunk_valid), 32'h0000_000f);
    // random stream with random valid and request
    for (int i = 0; i < 80; i++) add(2'($urandom_range(0, 3)), i == 79 || $urandom_range(0, 7) == 0);
    for (int k = 0; k < 400 && src_i < src_b.size(); k++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
    drain(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
